// File: rtl/select_1xn_if.sv
// select_1xn_if: sample/frame bus between the result producer (master)
// and the round-robin channel selector (slave).
//   start, latency_in, in           : producer -> selector
//   out, wea, addr, busy, done,
//   ovf_cnt                         : selector -> channel memories / status
interface select_1xn_if #(
   parameter int unsigned INT_BITS  = 20,
   parameter int unsigned N_CH      = 2,
   parameter int unsigned ADDR_BITS = 10
);
   logic                 start;
   logic                 latency_in;
   logic [INT_BITS-1:0]  in;
   logic [INT_BITS-1:0]  out;
   logic [N_CH-1:0]      wea;
   logic [ADDR_BITS-1:0] addr;
   logic                 busy;
   logic                 done;
   logic [7:0]           ovf_cnt;

   modport master (
      output start, latency_in, in,
      input  out, wea, addr, busy, done, ovf_cnt
   );

   modport slave (
      input  start, latency_in, in,
      output out, wea, addr, busy, done, ovf_cnt
   );
endinterface

// File: rtl/select_1xn.sv
// select_1xn: captures one sample per rising edge of latency_in and deals
// the samples round-robin over N_CH channels, producing a one-hot write
// enable and per-channel address for parallel BRAM ports. Frames hold
// N_CH*DEPTH samples and are armed by start.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : select_1xn_if.slave (start, latency_in, in -> out, wea, addr,
//            busy, done, ovf_cnt)
// Optional feature: define SELECT_1XN_OVERFLOW_CNT_EN to count strobes
// dropped while FULL (saturating at 255); otherwise ovf_cnt is tied to 0.
module select_1xn #(
   parameter int unsigned INT_BITS  = 20,
   parameter int unsigned N_CH      = 2,
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned ADDR_BITS = 10
) (
   input logic        clk,
   input logic        reset,
   select_1xn_if.slave bus
);
   localparam int unsigned CH_BITS = (N_CH > 1) ? $clog2(N_CH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

   state_t               state;
   logic                 lat_d;
   logic [CH_BITS-1:0]   ch;
   logic [ADDR_BITS-1:0] idx;
   logic [INT_BITS-1:0]  out_q;
   logic [N_CH-1:0]      wea_q;
   logic [ADDR_BITS-1:0] addr_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 strobe_c;
   logic                 last_c;

   // Rising edge of the strobe level; a held-high level captures once.
   assign strobe_c = bus.latency_in & ~lat_d;

   // Current capture writes the final sample of the frame.
   assign last_c = (ch == CH_BITS'(N_CH - 1)) && (idx == ADDR_BITS'(DEPTH - 1));

`ifdef SELECT_1XN_OVERFLOW_CNT_EN
   logic [7:0] ovf_q;
`endif

   // Frame FSM, channel/index counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         lat_d  <= 1'b0;
         ch     <= '0;
         idx    <= '0;
         out_q  <= '0;
         wea_q  <= '0;
         addr_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
`ifdef SELECT_1XN_OVERFLOW_CNT_EN
         ovf_q  <= '0;
`endif
      end else begin
         lat_d  <= bus.latency_in;
         wea_q  <= '0;
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state  <= RUN;
                  ch     <= '0;
                  idx    <= '0;
                  busy_q <= 1'b1;
`ifdef SELECT_1XN_OVERFLOW_CNT_EN
                  ovf_q  <= '0;
`endif
               end
            end
            RUN: begin
               if (strobe_c) begin
                  out_q  <= bus.in;
                  wea_q  <= N_CH'(1) << ch;
                  addr_q <= idx;
                  if (last_c) begin
                     state  <= FULL;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end else if (ch == CH_BITS'(N_CH - 1)) begin
                     ch  <= '0;
                     idx <= idx + ADDR_BITS'(1);
                  end else begin
                     ch <= ch + CH_BITS'(1);
                  end
               end
            end
            FULL: begin
               // start takes priority over a same-edge strobe
               if (bus.start) begin
                  state  <= RUN;
                  ch     <= '0;
                  idx    <= '0;
                  busy_q <= 1'b1;
`ifdef SELECT_1XN_OVERFLOW_CNT_EN
                  ovf_q  <= '0;
`endif
               end
`ifdef SELECT_1XN_OVERFLOW_CNT_EN
               else if (strobe_c && (ovf_q != 8'hFF)) begin
                  ovf_q <= ovf_q + 8'd1;
               end
`endif
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out  = out_q;
   assign bus.wea  = wea_q;
   assign bus.addr = addr_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

`ifdef SELECT_1XN_OVERFLOW_CNT_EN
   assign bus.ovf_cnt = ovf_q;
`else
   assign bus.ovf_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_select_1xn.sv
// tb_select_1xn: drives two selector instances (2 channels x 4 deep and
// 3 channels x 2 deep) from shared stimulus; a frame-level model predicts
// every output each cycle, and directed sequences pin literal values.
module tb_select_1xn;
   localparam int unsigned INT_BITS = 20;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                start = 1'b0;
   logic                lat = 1'b0;
   logic [INT_BITS-1:0] din = '0;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   select_1xn_if #(.INT_BITS(INT_BITS), .N_CH(2), .ADDR_BITS(2)) b2 ();
   select_1xn_if #(.INT_BITS(INT_BITS), .N_CH(3), .ADDR_BITS(1)) b3 ();

   assign b2.start = start;  assign b2.latency_in = lat;  assign b2.in = din;
   assign b3.start = start;  assign b3.latency_in = lat;  assign b3.in = din;

   select_1xn #(.INT_BITS(INT_BITS), .N_CH(2), .DEPTH(4), .ADDR_BITS(2))
      u_dut2 (.clk(clk), .reset(reset), .bus(b2));
   select_1xn #(.INT_BITS(INT_BITS), .N_CH(3), .DEPTH(2), .ADDR_BITS(1))
      u_dut3 (.clk(clk), .reset(reset), .bus(b3));

   task automatic check(input string name, input int inst,
                        input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[inst%0d] t=%0t: got %0h expected %0h",
                  name, inst, $time, act, exp);
      end
   endtask

   // Frame-level model: sample k of a frame lands in channel k%N at k/N.
   int          n_ch[2] = '{2, 3};
   int          dep[2]  = '{4, 2};
   int          m_mode[2];            // 0 idle, 1 running, 2 frame full
   int          m_k[2];
   bit          m_lat[2];
   logic [31:0] e_out[2], e_wea[2], e_addr[2], e_ovf[2];
   logic [31:0] e_busy[2], e_done[2];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_mode[i] = 0; m_k[i] = 0; m_lat[i] = 1'b0;
            e_out[i] = 0; e_wea[i] = 0; e_addr[i] = 0;
            e_busy[i] = 0; e_done[i] = 0; e_ovf[i] = 0;
         end else begin
            bit rise;
            rise = lat && !m_lat[i];
            e_wea[i] = 0;
            e_done[i] = 0;
            if (m_mode[i] == 1) begin
               if (rise) begin
                  e_out[i]  = 32'(din);
                  e_wea[i]  = 32'(1) << (m_k[i] % n_ch[i]);
                  e_addr[i] = 32'(m_k[i] / n_ch[i]);
                  m_k[i]++;
                  if (m_k[i] == n_ch[i] * dep[i]) begin
                     m_mode[i] = 2;
                     e_done[i] = 1;
                  end
               end
            end else if (start) begin
               m_mode[i] = 1; m_k[i] = 0; e_ovf[i] = 0;
            end else if (m_mode[i] == 2 && rise) begin
`ifdef SELECT_1XN_OVERFLOW_CNT_EN
               if (e_ovf[i] < 255) e_ovf[i] = e_ovf[i] + 1;
`endif
            end
            m_lat[i] = lat;
            e_busy[i] = (m_mode[i] == 1) ? 1 : 0;
         end
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("out",  0, 32'(b2.out),  e_out[0]);
         check("wea",  0, 32'(b2.wea),  e_wea[0]);
         check("addr", 0, 32'(b2.addr), e_addr[0]);
         check("busy", 0, 32'(b2.busy), e_busy[0]);
         check("done", 0, 32'(b2.done), e_done[0]);
         check("ovf",  0, 32'(b2.ovf_cnt), e_ovf[0]);
         check("out",  1, 32'(b3.out),  e_out[1]);
         check("wea",  1, 32'(b3.wea),  e_wea[1]);
         check("addr", 1, 32'(b3.addr), e_addr[1]);
         check("busy", 1, 32'(b3.busy), e_busy[1]);
         check("done", 1, 32'(b3.done), e_done[1]);
         check("ovf",  1, 32'(b3.ovf_cnt), e_ovf[1]);
      end
   end

   task automatic do_reset();
      @(negedge clk); reset = 1'b1; start = 1'b0; lat = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   // Raise the strobe for one cycle; returns when the capture is visible.
   task automatic pulse(input logic [INT_BITS-1:0] v);
      @(negedge clk); lat = 1'b1; din = v;
      @(negedge clk); lat = 1'b0;
   endtask

   logic [31:0] wea2_tab[8]  = '{1, 2, 1, 2, 1, 2, 1, 2};
   logic [31:0] addr2_tab[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
   logic [31:0] wea3_tab[6]  = '{1, 2, 4, 1, 2, 4};
   logic [31:0] addr3_tab[6] = '{0, 0, 0, 1, 1, 1};

   initial begin
      int cnt;
      do_reset();
      chk_en = 1'b1;

      // Strobes without start are ignored.
      for (int i = 0; i < 3; i++) begin
         pulse(20'(i + 5));
         check("idle_wea", 0, 32'(b2.wea), 0);
         check("idle_busy", 0, 32'(b2.busy), 0);
         check("idle_out", 0, 32'(b2.out), 0);
      end

      // One full 2x4 frame.
      pulse_start();
      check("start_busy", 0, 32'(b2.busy), 1);
      for (int i = 0; i < 8; i++) begin
         pulse(20'(i + 1));
         check("frame_wea", 0, 32'(b2.wea), wea2_tab[i]);
         check("frame_addr", 0, 32'(b2.addr), addr2_tab[i]);
         check("frame_out", 0, 32'(b2.out), 32'(i + 1));
         check("frame_done", 0, 32'(b2.done), (i == 7) ? 1 : 0);
      end
      check("frame_busy_end", 0, 32'(b2.busy), 0);

      // A level held high captures once.
      do_reset();
      pulse_start();
      cnt = 0;
      @(negedge clk); lat = 1'b1; din = 20'h5a5a5;
      repeat (5) begin
         @(negedge clk);
         if (b2.wea != '0) cnt++;
      end
      lat = 1'b0;
      @(negedge clk);
      if (b2.wea != '0) cnt++;
      check("held_level_pulses", 0, 32'(cnt), 1);

      // Overflow in FULL, then re-arm.
      do_reset();
      pulse_start();
      for (int i = 0; i < 8; i++) pulse(20'(i));
      cnt = 0;
      for (int i = 0; i < 300; i++) begin
         pulse(20'(i));
         if (b2.wea != '0) cnt++;
      end
      check("full_no_wea", 0, 32'(cnt), 0);
`ifdef SELECT_1XN_OVERFLOW_CNT_EN
      check("ovf_sat", 0, 32'(b2.ovf_cnt), 255);
`else
      check("ovf_tied", 0, 32'(b2.ovf_cnt), 0);
`endif
      pulse_start();
      check("rearm_ovf", 0, 32'(b2.ovf_cnt), 0);
      pulse(20'h00abc);
      check("rearm_wea", 0, 32'(b2.wea), 1);
      check("rearm_addr", 0, 32'(b2.addr), 0);

      // Reset mid-frame with a strobe on the same edge.
      do_reset();
      pulse_start();
      for (int i = 0; i < 5; i++) pulse(20'(i + 16));
      @(negedge clk); reset = 1'b1; lat = 1'b1;
      @(negedge clk);
      check("rst_wea", 0, 32'(b2.wea), 0);
      check("rst_out", 0, 32'(b2.out), 0);
      check("rst_addr", 0, 32'(b2.addr), 0);
      check("rst_busy", 0, 32'(b2.busy), 0);
      check("rst_done", 0, 32'(b2.done), 0);
      reset = 1'b0; lat = 1'b0;
      pulse_start();
      pulse(20'h00077);
      check("post_rst_wea", 0, 32'(b2.wea), 1);
      check("post_rst_addr", 0, 32'(b2.addr), 0);

      // 3x2: start and strobe on the same edge, then a full frame.
      do_reset();
      @(negedge clk); start = 1'b1; lat = 1'b1; din = 20'hfffff;
      @(negedge clk);
      check("same_edge_wea", 1, 32'(b3.wea), 0);
      check("same_edge_busy", 1, 32'(b3.busy), 1);
      start = 1'b0; lat = 1'b0;
      for (int i = 0; i < 6; i++) begin
         pulse(20'(i + 32));
         check("f3_wea", 1, 32'(b3.wea), wea3_tab[i]);
         check("f3_addr", 1, 32'(b3.addr), addr3_tab[i]);
         check("f3_done", 1, 32'(b3.done), (i == 5) ? 1 : 0);
      end

      // Randomized traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 199) == 0);
         start = ($urandom_range(0, 29) == 0);
         lat   = 1'($urandom_range(0, 1));
         din   = 20'($urandom);
      end
      @(negedge clk); reset = 1'b0; start = 1'b0; lat = 1'b0;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
